// File: rtl/rotater.sv
// Rotate/swap unit for the PDP-8 operate path: RAR/RAL/RTR/RTL/BSW on the {link, AC} ring, one step per clock.
// Latency: NOP 1 cycle, RAR/RAL/BSW 2 cycles, RTR/RTL 3 cycles from the accepting edge to DONE.
// Backpressure: none; START is accepted only in IDLE/DONE and is dropped while BUSY.
module rotater #(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             START,
    input  logic [2:0]       OP,
    input  logic [WIDTH-1:0] AC_IN,
    input  logic             LINK_IN,
    output logic [WIDTH-1:0] AC_OUT,
    output logic             LINK_OUT,
    output logic             BUSY,
    output logic             DONE
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        M_RIGHT,
        M_LEFT,
        M_SWAP
    } mode_t;

    state_t       state, state_n;
    mode_t        mode, mode_n;
    logic [WIDTH:0] ring, ring_n;   // {link, ac}
    logic [1:0]   count, count_n;
    logic [1:0]   op_cnt;
    mode_t        op_mode;

    // Operation decode: step count and direction for the requested OP.
    always_comb begin
        op_cnt  = 2'd0;
        op_mode = M_RIGHT;
        case (OP)
            3'd1: begin op_cnt = 2'd1; op_mode = M_RIGHT; end
            3'd2: begin op_cnt = 2'd1; op_mode = M_LEFT;  end
            3'd3: begin op_cnt = 2'd2; op_mode = M_RIGHT; end
            3'd4: begin op_cnt = 2'd2; op_mode = M_LEFT;  end
            3'd5: begin op_cnt = 2'd1; op_mode = M_SWAP;  end
            default: begin op_cnt = 2'd0; op_mode = M_RIGHT; end
        endcase
    end

    always_comb begin
        state_n = state;
        mode_n  = mode;
        ring_n  = ring;
        count_n = count;
        case (state)
            S_IDLE, S_DONE: begin
                if (START) begin
                    ring_n  = {LINK_IN, AC_IN};
                    mode_n  = op_mode;
                    count_n = op_cnt;
                    state_n = (op_cnt != 2'd0) ? S_SHIFT : S_DONE;
                end else begin
                    state_n = S_IDLE;
                end
            end
            S_SHIFT: begin
                case (mode)
                    M_RIGHT: ring_n = {ring[0], ring[WIDTH:1]};
                    M_LEFT:  ring_n = {ring[WIDTH-1:0], ring[WIDTH]};
                    M_SWAP:  ring_n = {ring[WIDTH], ring[WIDTH/2-1:0], ring[WIDTH-1:WIDTH/2]};
                    default: ring_n = ring;
                endcase
                count_n = count - 2'd1;
                if (count <= 2'd1) begin
                    state_n = S_DONE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            mode  <= M_RIGHT;
            ring  <= '0;
            count <= 2'd0;
        end else begin
            state <= state_n;
            mode  <= mode_n;
            ring  <= ring_n;
            count <= count_n;
        end
    end

    assign AC_OUT   = ring[WIDTH-1:0];
    assign LINK_OUT = ring[WIDTH];
    assign BUSY     = (state == S_SHIFT);
    assign DONE     = (state == S_DONE);

endmodule

// File: tb/tb_rotater.sv
// Directed bench for rotater: vector table for single operations plus hand-written
// sequences for START-while-busy, back-to-back and mid-operation reset.
module tb_rotater;

    logic        clk;
    logic        reset;
    logic        START;
    logic [2:0]  OP;
    logic [11:0] AC_IN;
    logic        LINK_IN;
    logic [11:0] AC_OUT;
    logic        LINK_OUT;
    logic        BUSY;
    logic        DONE;

    int checks = 0;
    int failures = 0;

    rotater #(.WIDTH(12)) dut (
        .clk      (clk),
        .reset    (reset),
        .START    (START),
        .OP       (OP),
        .AC_IN    (AC_IN),
        .LINK_IN  (LINK_IN),
        .AC_OUT   (AC_OUT),
        .LINK_OUT (LINK_OUT),
        .BUSY     (BUSY),
        .DONE     (DONE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic        l;
        logic [11:0] ac;
        logic        el;
        logic [11:0] eac;
        int          lat;
        int          busy;
        bit          chk_mid;
        logic        ml;
        logic [11:0] mac;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int lat = 0;
        int busy = 0;
        logic        dl = 1'b0;
        logic [11:0] dac = '0;
        logic        mdl = 1'b0;
        logic [11:0] mdac = '0;
        @(posedge clk); #1;
        START = 1'b1; OP = v.op; LINK_IN = v.l; AC_IN = v.ac;
        @(posedge clk); #1;
        // Operands are only sampled on the accepting edge; scramble them afterwards.
        START = 1'b0; OP = 3'd4; LINK_IN = ~v.l; AC_IN = ~v.ac;
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            if (BUSY) begin
                busy++;
                mdl = LINK_OUT;
                mdac = AC_OUT;
            end
            if (DONE) begin
                lat = n;
                dl = LINK_OUT;
                dac = AC_OUT;
                break;
            end
            @(posedge clk); #1;
        end
        check({v.name, " latency"}, lat, v.lat);
        check({v.name, " busy_cycles"}, busy, v.busy);
        check({v.name, " link"}, {31'd0, dl}, {31'd0, v.el});
        check({v.name, " ac"}, {20'd0, dac}, {20'd0, v.eac});
        if (v.chk_mid)
            check({v.name, " intermediate"}, {19'd0, mdl, mdac}, {19'd0, v.ml, v.mac});
        @(negedge clk);
        check({v.name, " done_one_pulse"}, {31'd0, DONE}, 32'd0);
    endtask

    initial begin
        int dn;
        int lat;
        logic        rl;
        logic [11:0] rac;
        logic [5:0]  done_seq;
        logic [5:0]  busy_seq;
        logic        l_v[6];
        logic [11:0] ac_v[6];

        vecs[0] = '{"RAL", 3'd2, 1'b0, 12'o4001, 1'b1, 12'o0002, 2, 1, 1'b0, 1'b0, 12'o0};
        vecs[1] = '{"RAR", 3'd1, 1'b1, 12'o0001, 1'b1, 12'o4000, 2, 1, 1'b0, 1'b0, 12'o0};
        vecs[2] = '{"RTL", 3'd4, 1'b0, 12'o6000, 1'b1, 12'o0001, 3, 2, 1'b1, 1'b1, 12'o4000};
        vecs[3] = '{"BSW", 3'd5, 1'b1, 12'o1234, 1'b1, 12'o3412, 2, 1, 1'b0, 1'b0, 12'o0};
        vecs[4] = '{"NOP", 3'd0, 1'b1, 12'o7070, 1'b1, 12'o7070, 1, 0, 1'b0, 1'b0, 12'o0};

        // Reset held with a live request pending
        reset = 1'b0; START = 1'b1; OP = 3'd2; AC_IN = 12'o7777; LINK_IN = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset ac", {20'd0, AC_OUT}, 32'd0);
        check("reset link", {31'd0, LINK_OUT}, 32'd0);
        check("reset busy", {31'd0, BUSY}, 32'd0);
        check("reset done", {31'd0, DONE}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1; START = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle after reset", {17'd0, LINK_OUT, AC_OUT, BUSY, DONE}, 32'd0);
        end

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // START during SHIFT must be ignored: RTR of {0,0003} gives {1,4000}
        @(posedge clk); #1;
        START = 1'b1; OP = 3'd3; LINK_IN = 1'b0; AC_IN = 12'o0003;
        @(posedge clk); #1;
        START = 1'b1; OP = 3'd2; LINK_IN = 1'b1; AC_IN = 12'o7777;
        dn = 0; lat = 0; rl = 1'b0; rac = '0;
        @(negedge clk);
        if (DONE) dn++;
        @(posedge clk); #1;
        START = 1'b0;
        for (int n = 2; n <= 6; n++) begin
            @(negedge clk);
            if (DONE) begin
                dn++;
                if (lat == 0) begin
                    lat = n; rl = LINK_OUT; rac = AC_OUT;
                end
            end
            @(posedge clk); #1;
        end
        check("busy_start done_count", dn, 1);
        check("busy_start latency", lat, 3);
        check("busy_start link", {31'd0, rl}, 32'd1);
        check("busy_start ac", {20'd0, rac}, {20'd0, 12'o4000});

        // Back-to-back: RAL {0,4001} then RAR {1,0006} accepted on the DONE edge
        START = 1'b1; OP = 3'd2; LINK_IN = 1'b0; AC_IN = 12'o4001;
        @(posedge clk); #1;
        OP = 3'd1; LINK_IN = 1'b1; AC_IN = 12'o0006;
        done_seq = '0; busy_seq = '0;
        for (int n = 1; n <= 5; n++) begin
            @(negedge clk);
            done_seq[n] = DONE;
            busy_seq[n] = BUSY;
            l_v[n] = LINK_OUT;
            ac_v[n] = AC_OUT;
            @(posedge clk); #1;
            if (n == 2) START = 1'b0;
        end
        check("b2b done_pattern", {26'd0, done_seq}, {26'd0, 6'b010100});
        check("b2b busy_pattern", {26'd0, busy_seq}, {26'd0, 6'b001010});
        check("b2b first_result", {19'd0, l_v[2], ac_v[2]}, {19'd0, 1'b1, 12'o0002});
        check("b2b second_result", {19'd0, l_v[4], ac_v[4]}, {19'd0, 1'b0, 12'o4003});

        // Reset in the middle of RTL after one step
        @(posedge clk); #1;
        START = 1'b1; OP = 3'd4; LINK_IN = 1'b0; AC_IN = 12'o6000;
        @(posedge clk); #1;
        START = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midreset pre_state", {18'd0, BUSY, LINK_OUT, AC_OUT}, {18'd0, 1'b1, 1'b1, 12'o4000});
        #2 reset = 1'b0;
        #1;
        check("midreset immediate", {17'd0, LINK_OUT, AC_OUT, BUSY, DONE}, 32'd0);
        dn = 0;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            if (DONE || BUSY) dn++;
        end
        check("midreset no_done", dn, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("midreset idle", {17'd0, LINK_OUT, AC_OUT, BUSY, DONE}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
